// File: rtl/ins_fetch_pkg.sv
// Shared types for the instruction fetch stage.
package ins_fetch_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fetch_state_t;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fetch_buf.sv
// Two-entry skid FIFO holding {address, instruction} pairs between RAM and decoder.
module fetch_buf
    import ins_fetch_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (pop) begin
            ent0 <= (push && count == CNT_W'(1)) ? din : ent1;
            if (push && count == CNT_W'(2)) begin
                ent1 <= din;
            end
        end else if (push) begin
            if (count == '0) begin
                ent0 <= din;
            end else begin
                ent1 <= din;
            end
        end
    end

    assign dout = ent0;

endmodule

// File: rtl/ins_fetch.sv
// Fetch stage: FSM, program counter and issue throttling in front of a 1-cycle instruction RAM.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int                    INS_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  jmpEn,
    input  logic [ADDR_WIDTH-1:0] jmpAddr,
    input  logic                  endOp,
    output logic [ADDR_WIDTH-1:0] insAddr,
    input  logic [INS_WIDTH-1:0]  insData,
    output logic [INS_WIDTH-1:0]  insOut,
    output logic [ADDR_WIDTH-1:0] pcOut,
    output logic                  insValid,
    input  logic                  insReady,
    output logic                  busy,
    output logic                  done
);

    localparam int ENT_W = ADDR_WIDTH + INS_WIDTH;

    fetch_state_t            state;
    fetch_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    vld_p1;
    logic [ADDR_WIDTH-1:0]   addr_p1;
    logic [CNT_W-1:0]        count;
    logic [ENT_W-1:0]        head;
    logic [2:0]              occ;
    logic                    in_run;
    logic                    stop;
    logic                    jump;
    logic                    pop;
    logic                    issue;
    logic                    push;

    assign in_run = (state == RUN);
    assign stop   = in_run && endOp;
    assign jump   = in_run && jmpEn && !endOp;
    assign pop    = insValid && insReady;

    // A slot is claimed at issue time so a stalled decoder never sees more than two words.
    assign occ   = {{(3-CNT_W){1'b0}}, count} + {2'b00, vld_p1};
    assign issue = in_run && !endOp && !jmpEn && (occ < (3'd2 + {2'b00, pop}));
    assign push  = in_run && !endOp && !jmpEn && vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (endOp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            pc <= START_ADDR;
        end else if (jump) begin
            pc <= jmpAddr;
        end else if (issue) begin
            pc <= pc + 1'b1;
        end
    end

    // Stage 1: address presented to RAM, data returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            addr_p1 <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= stop;
        end
    end

    fetch_buf #(
        .DATA_W (ENT_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clear (stop || jump),
        .push  (push),
        .pop   (pop),
        .din   ({addr_p1, insData}),
        .dout  (head),
        .count (count)
    );

    assign insAddr  = pc;
    assign insValid = (count != '0);
    assign {pcOut, insOut} = insValid ? head : '0;

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch stage for each processor core. Owns the program counter and drives the address port of the core's instruction RAM (registered-address, 8-bit words). It absorbs the RAM's read latency and delivers instructions in program order to the decoder over a valid/ready handshake. Supports start, jump redirect and end-of-program stop.

## Interface
Parameters:
- INS_WIDTH, 8, instruction word width; equals instruction RAM WIDTH
- ADDR_WIDTH, 8, PC / RAM address width; equals instruction RAM ADDR_WIDTH
- START_ADDR, 0, PC value loaded on reset, start and end

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  pulse; begins fetching at START_ADDR; ignored unless IDLE
- jmpEn  input  1  redirect request from decoder; valid only in RUN
- jmpAddr  input  ADDR_WIDTH  jump target
- endOp  input  1  decoder saw END; stop fetching
- insAddr  output  ADDR_WIDTH  address to instruction RAM (current PC)
- insData  input  INS_WIDTH  instruction RAM read data
- insOut  output  INS_WIDTH  instruction to decoder
- pcOut  output  ADDR_WIDTH  address of insOut
- insValid  output  1  insOut/pcOut valid
- insReady  input  1  decoder accepts; transfer when insValid && insReady
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on leaving RUN via endOp

## Operation
- States: IDLE, RUN. IDLE->RUN on start. RUN->IDLE on endOp.
- RAM contract: address on insAddr in cycle n returns data on insData in cycle n+1.
- Issue: in RUN, an address issues in cycle n iff (count + inflight - pop) < 2. Here count = buffer entries, inflight = 1 if an issue occurred in n-1, and pop = insValid && insReady. On issue, PC <= PC+1, modulo 2^ADDR_WIDTH (255 wraps to 0).
- Capture: when inflight, {insData, issued address} is pushed into the 2-entry buffer at the end of the arrival cycle.
- Head of buffer drives insOut/pcOut; insValid = count != 0. Outputs hold stable while insValid && !insReady.
- Priority per cycle: rst > endOp > jmpEn > issue/capture. A pop in the same cycle always completes.
- jmpEn: buffer cleared, inflight cleared (the arriving word next cycle is dropped), PC <= jmpAddr, no issue in that cycle. jmpAddr issues in the next cycle.
- endOp: buffer and inflight cleared, PC <= START_ADDR, state IDLE, done = 1 for one cycle.
- start in RUN, and jmpEn/endOp in IDLE: ignored.

## Timing
- Reset values: state IDLE, PC = START_ADDR, insAddr = START_ADDR, count = 0, inflight = 0, insValid = 0, insOut = 0, pcOut = 0, busy = 0, done = 0.
- start sampled at edge of cycle 0. busy = 1 and first issue of START_ADDR in cycle 1. Data on insData in cycle 2. insValid first high in cycle 3.
- With insReady held high: one instruction per cycle sustained, no bubbles.
- Jump latency: jmpEn in cycle t -> insValid low in t+1 -> target valid in t+3.
- Backpressure: at most 2 buffered words plus 0 in flight when stalled. No word is lost or duplicated.
- rst mid-RUN: returns to reset values next cycle. No done pulse.

## Structure
- Shared package details: typedef fetch_state_t {IDLE, RUN}.
- Sub-module fetch_buf: 2-entry FIFO of {addr, ins} with push, pop, clear, count. The skid logic lives there; ins_fetch holds the FSM, PC and issue logic.

## Test plan
- Reset then start with RAM preloaded mem[i] = i+1, insReady = 1: insValid rises cycle 3. Stream 1,2,3… with pcOut 0,1,2…, one per cycle.
- Hold insReady = 0 for 5 cycles mid-stream: insAddr stops advancing after 2 buffered words. On release, no gap, loss or repeat in the sequence.
- jmpEn with jmpAddr = 0x40 while word at pc 5 is accepted: words from pc 6/7 are never presented. Next valid word has pcOut = 0x40, 2 cycles after insValid drops.
- Start at START_ADDR = 0xFE, insReady = 1: pcOut sequence FE, FF, 00, 01.
- endOp while 2 words are buffered: done pulses 1 cycle, busy = 0 and insValid = 0 next cycle, insAddr = START_ADDR. A later start refetches from START_ADDR.
- Assert rst during RUN with a full buffer: all outputs at reset values next cycle, no done pulse.
